// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR filter.
// Default widths, FSM encoding and a constant clog2 helper.
package fir_pkg;

    localparam int FIR_WIN   = 16;
    localparam int FIR_WC    = 18;
    localparam int FIR_NTAPS = 17;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } fir_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mac_core.sv
// Pipelined signed multiply-accumulate: operand regs, product reg, accumulator.
// A valid bit travels with each operand pair so only real taps accumulate.
module mac_core #(
    parameter int WA   = 18,
    parameter int WB   = 16,
    parameter int WACC = 39
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   en,
    input  logic signed [WA-1:0]   a,
    input  logic signed [WB-1:0]   b,
    output logic signed [WACC-1:0] acc
);

    logic signed [WA-1:0]    a_q;
    logic signed [WB-1:0]    b_q;
    logic signed [WA+WB-1:0] p_q;
    logic                    v1;
    logic                    v2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
            v1  <= 1'b0;
            v2  <= 1'b0;
            acc <= '0;
        end else if (clear) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            acc <= '0;
        end else begin
            a_q <= a;
            b_q <= b;
            v1  <= en;
            p_q <= (WA+WB)'(a_q) * (WA+WB)'(b_q);
            v2  <= v1;
            if (v2) acc <= acc + WACC'(p_q);
        end
    end

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one MAC walks all taps per accepted sample.
// Owns the delay line, coefficient bank, tap sequencing and output register.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int Win   = FIR_WIN,
    parameter int Wc    = FIR_WC,
    parameter int NTAPS = FIR_NTAPS
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    clr,
    input  logic                                    coef_we,
    input  logic [clog2(NTAPS)-1:0]                 coef_addr,
    input  logic signed [Wc-1:0]                    coef_wdata,
    input  logic signed [Win-1:0]                   din,
    input  logic                                    din_valid,
    output logic                                    din_ready,
    output logic signed [Win+Wc+clog2(NTAPS)-1:0]   dout,
    output logic                                    dout_valid,
    output logic                                    busy
);

    localparam int AW   = clog2(NTAPS);
    localparam int Wacc = Win + Wc + AW;
    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

    fir_state_t state, state_nx;

    logic [AW-1:0]          k;
    logic [AW-1:0]          wr_ptr;
    logic [AW:0]            fill;
    logic [AW-1:0]          rd_idx;
    logic signed [Wc-1:0]   coef [NTAPS];
    logic signed [Win-1:0]  hist [NTAPS];
    logic signed [Wc-1:0]   tap_h;
    logic signed [Win-1:0]  tap_x;
    logic signed [Wacc-1:0] acc;
    logic                   idle;
    logic                   accept;
    logic                   flush;
    logic                   mac_en;
    logic                   coef_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (din_valid && !clr) state_nx = S_MAC;
            S_MAC:   if (k == LAST) state_nx = S_DRAIN;
            S_DRAIN: if (k == AW'(1)) state_nx = S_OUT;
            S_OUT:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        idle      = (state == S_IDLE);
        din_ready = idle;
        busy      = !idle;
        accept    = idle && din_valid && !clr;
        flush     = idle && clr;
        mac_en    = (state == S_MAC);
    end

    // k indexes taps in MAC, then counts the two drain cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k <= '0;
        end else if (accept) begin
            k <= '0;
        end else if (mac_en) begin
            k <= (k == LAST) ? '0 : k + 1'b1;
        end else if (state == S_DRAIN) begin
            k <= k + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            if (accept && fill != (AW+1)'(NTAPS)) fill <= fill + 1'b1;
            if (state == S_OUT) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        end
    end

    assign coef_ok = ({1'b0, coef_addr} < (AW+1)'(NTAPS));

    // Storage arrays carry no reset: the bank survives reset, history is gated by fill
    always_ff @(posedge clk) begin
        if (accept) hist[wr_ptr] <= din;
        if (idle && coef_we && coef_ok) coef[coef_addr] <= coef_wdata;
    end

    always_comb begin
        rd_idx = (wr_ptr >= k) ? wr_ptr - k : wr_ptr + AW'(NTAPS) - k;
        tap_h  = coef[k];
        tap_x  = ({1'b0, k} < fill) ? hist[rd_idx] : '0;
    end

    mac_core #(
        .WA   (Wc),
        .WB   (Win),
        .WACC (Wacc)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (mac_en),
        .a     (tap_h),
        .b     (tap_x),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= (state == S_OUT);
            if (state == S_OUT) dout <= acc;
        end
    end

endmodule
